// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage hazard detection, stall generation and HI/LO busy tracking
`timescale 1ns/1ps
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic        ex_regwrite,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_wreg,
  input  logic [1:0]  ex_md_op,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_flush,
  output logic        stall,
  output logic        md_busy,
  output logic [3:0]  md_count,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  typedef enum logic [1:0] {MD_IDLE, MD_MULT, MD_DIV} md_state_t;

  md_state_t   state, state_next;
  logic [3:0]  count, count_next;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt;
  logic        use_rs, use_rt, md_use_d, br_d;
  logic        ex_hit, mem_hit;
  logic        load_use, br_ex, br_mem, md_haz;
  logic        unused_ir;

  assign op = ir_d[31:26];
  assign fn = ir_d[5:0];
  assign rs = ir_d[25:21];
  assign rt = ir_d[20:16];
  // Immediate/rd/shamt bits never take part in hazard decisions.
  assign unused_ir = ^ir_d[15:6];

  // Decode which source fields the ID instruction actually reads.
  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    md_use_d = 1'b0;
    br_d     = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h00, 6'h02, 6'h03: use_rt = 1'b1;
        6'h08, 6'h09: begin
          use_rs = 1'b1;
          br_d   = 1'b1;
        end
        6'h10, 6'h12: md_use_d = 1'b1;
        default: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
      endcase
      if (fn inside {6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13}) md_use_d = 1'b1;
    end else begin
      case (op)
        6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: use_rs = 1'b1;
        6'h06, 6'h07: begin
          use_rs = 1'b1;
          br_d   = 1'b1;
        end
        6'h28, 6'h29, 6'h2b: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        6'h04, 6'h05: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
          br_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // $0 is hardwired, so a write to it can never be a producer.
  assign ex_hit  = (ex_wreg != 5'd0) &&
                   ((use_rs && (ex_wreg == rs)) || (use_rt && (ex_wreg == rt)));
  assign mem_hit = (mem_wreg != 5'd0) &&
                   ((use_rs && (mem_wreg == rs)) || (use_rt && (mem_wreg == rt)));

  assign load_use = ex_is_load && ex_hit;
  assign br_ex    = br_d && ex_regwrite && ex_hit;
  assign br_mem   = br_d && mem_is_load && mem_hit;
  assign md_haz   = md_use_d && (md_busy || (ex_md_op == 2'b01) || (ex_md_op == 2'b10));

  assign stall      = load_use || br_ex || br_mem || md_haz;
  assign pc_en      = ~stall;
  assign ifid_en    = ~stall;
  assign idex_flush = stall;

  assign md_busy  = (state != MD_IDLE);
  assign md_count = count;

  // HI/LO state and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Start a busy window on mult/div issue; ops arriving while busy are ignored.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      MD_IDLE: begin
        if (ex_md_op == 2'b01) begin
          state_next = MD_MULT;
          count_next = MULT_CNT;
        end else if (ex_md_op == 2'b10) begin
          state_next = MD_DIV;
          count_next = DIV_CNT;
        end
      end
      MD_MULT, MD_DIV: begin
        if (count == 4'd1) begin
          state_next = MD_IDLE;
          count_next = 4'd0;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: begin
        state_next = MD_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Performance counter of stalled cycles; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= 32'd0;
    else if (stall) stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic        ex_regwrite, ex_is_load, mem_is_load;
  logic [4:0]  ex_wreg, mem_wreg;
  logic [1:0]  ex_md_op;
  logic        pc_en, ifid_en, idex_flush, stall, md_busy;
  logic [3:0]  md_count;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // reference state: cycles of HI/LO work left, and stalled-cycle tally
  int          m_rem = 0;
  logic [31:0] m_cnt = 32'd0;

  hazard_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
    .mem_is_load(mem_is_load), .mem_wreg(mem_wreg), .ex_md_op(ex_md_op),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_flush(idex_flush), .stall(stall),
    .md_busy(md_busy), .md_count(md_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Set of registers read in ID, following the instruction-class rules.
  function automatic void ref_srcs(input logic [31:0] ir, output int r0, output int r1,
                                   output bit is_br, output bit is_md);
    int op, fn, rs, rt;
    op = int'(ir[31:26]); fn = int'(ir[5:0]); rs = int'(ir[25:21]); rt = int'(ir[20:16]);
    r0 = -1; r1 = -1; is_br = 0; is_md = 0;
    if (op == 0) begin
      if (fn == 0 || fn == 2 || fn == 3) r1 = rt;
      else if (fn == 8 || fn == 9) begin r0 = rs; is_br = 1; end
      else if (fn == 'h10 || fn == 'h12) is_md = 1;
      else begin r0 = rs; r1 = rt; end
      if (fn inside {'h18, 'h19, 'h1a, 'h1b, 'h11, 'h13}) is_md = 1;
    end else if ((op >= 'h09 && op <= 'h0e) || op inside {'h20, 'h21, 'h23, 'h24, 'h25}) r0 = rs;
    else if (op == 6 || op == 7) begin r0 = rs; is_br = 1; end
    else if (op inside {'h28, 'h29, 'h2b}) begin r0 = rs; r1 = rt; end
    else if (op == 4 || op == 5) begin r0 = rs; r1 = rt; is_br = 1; end
  endfunction

  function automatic bit ref_stall();
    int r0, r1;
    bit is_br, is_md, exm, memm;
    ref_srcs(ir_d, r0, r1, is_br, is_md);
    exm  = (ex_wreg != 0) && (int'(ex_wreg) == r0 || int'(ex_wreg) == r1);
    memm = (mem_wreg != 0) && (int'(mem_wreg) == r0 || int'(mem_wreg) == r1);
    return (ex_is_load && exm) || (is_br && ex_regwrite && exm) || (is_br && mem_is_load && memm) ||
           (is_md && (m_rem > 0 || ex_md_op == 2'b01 || ex_md_op == 2'b10));
  endfunction

  // Advance one clock and move the reference model along with it.
  task automatic tick();
    bit s;
    s = ref_stall();
    @(posedge clk);
    if (reset) begin
      m_rem = 0; m_cnt = 0;
    end else begin
      if (s) m_cnt = m_cnt + 1;
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (ex_md_op == 2'b01) m_rem = 5;
      else if (ex_md_op == 2'b10) m_rem = 10;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ir_d = 32'd0; ex_regwrite = 0; ex_is_load = 0; ex_wreg = 0;
    mem_is_load = 0; mem_wreg = 0; ex_md_op = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); tick(); tick(); reset = 0; #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", md_busy); end
    checks++; if (md_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", md_count); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_scyc got=%0d exp=0", stall_cycles); end
    checks++; if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin errors++; $display("FAIL reset_ctrl got=%b exp=110", {pc_en, ifid_en, idex_flush}); end
  endtask

  task automatic test_load_use();
    idle_inputs(); ex_is_load = 1; ex_wreg = 8; ir_d = 32'h010A4821; #1;
    checks++; if ({stall, pc_en, ifid_en, idex_flush} !== 4'b1001) begin errors++; $display("FAIL load_use got=%b exp=1001", {stall, pc_en, ifid_en, idex_flush}); end
    tick(); idle_inputs(); ex_is_load = 1; ex_wreg = 0; ir_d = rtype(0, 10, 9, 0, 'h21); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_r0 got=%0b exp=0", stall); end
    checks++; if (stall_cycles !== m_cnt) begin errors++; $display("FAIL load_use_scyc got=%0d exp=%0d", stall_cycles, m_cnt); end
    tick();
  endtask

  task automatic test_branch();
    idle_inputs(); ir_d = itype(4, 8, 9, 3); ex_regwrite = 1; ex_wreg = 9; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_ex got=%0b exp=1", stall); end
    tick(); idle_inputs(); ir_d = itype(4, 8, 9, 3); mem_is_load = 1; mem_wreg = 8; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_mem got=%0b exp=1", stall); end
    tick(); idle_inputs(); ir_d = 32'h010A4821; ex_regwrite = 1; ex_wreg = 10; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_fwd got=%0b exp=0", stall); end
    tick();
  endtask

  task automatic test_shift();
    idle_inputs(); ir_d = rtype(0, 8, 2, 4, 0); ex_is_load = 1; ex_wreg = 8; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sll_rt got=%0b exp=1", stall); end
    tick(); idle_inputs(); ir_d = rtype(7, 8, 2, 4, 0); ex_is_load = 1; ex_wreg = 7; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sll_rs got=%0b exp=0", stall); end
    tick();
  endtask

  task automatic test_mult();
    do_reset(); idle_inputs(); ex_md_op = 2'b01; ir_d = rtype(0, 0, 4, 0, 'h12); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mult_issue got=%0b exp=1", stall); end
    tick(); ex_md_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({md_busy, stall, md_count} !== {2'b11, 4'(5 - i)}) begin errors++; $display("FAIL mult_busy[%0d] got=%b/%0d exp=11/%0d", i, {md_busy, stall}, md_count, 5 - i); end
      tick();
    end
    #1;
    checks++; if ({md_busy, stall} !== 2'b00) begin errors++; $display("FAIL mult_done got=%b exp=00", {md_busy, stall}); end
    checks++; if (stall_cycles !== 32'd6) begin errors++; $display("FAIL mult_scyc got=%0d exp=6", stall_cycles); end
  endtask

  task automatic test_div();
    idle_inputs(); ex_md_op = 2'b10; tick(); ex_md_op = 2'b00;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (md_count !== 4'(10 - i) || md_busy !== 1'b1) begin errors++; $display("FAIL div_count[%0d] got=%0d exp=%0d", i, md_count, 10 - i); end
      tick();
    end
    #1;
    checks++; if ({md_busy, md_count} !== 5'd0) begin errors++; $display("FAIL div_done got=%b/%0d exp=0/0", md_busy, md_count); end
    ex_md_op = 2'b10; ir_d = rtype(0, 0, 4, 0, 'h10); tick(); ex_md_op = 2'b00;
    for (int i = 0; i < 20 && md_count != 4'd4; i++) tick();
    checks++; if (md_count !== 4'd4) begin errors++; $display("FAIL div_reach4 got=%0d exp=4", md_count); end
    do_reset(); #1;
    checks++; if ({md_busy, md_count} !== 5'd0 || stall_cycles !== 32'd0) begin errors++; $display("FAIL div_abort got=%b/%0d/%0d exp=0/0/0", md_busy, md_count, stall_cycles); end
  endtask

  task automatic test_mthi();
    idle_inputs(); ex_md_op = 2'b11; ir_d = rtype(0, 0, 5, 0, 'h10); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_issue got=%0b exp=0", stall); end
    tick(); ex_md_op = 2'b00; #1;
    checks++; if ({md_busy, stall} !== 2'b00) begin errors++; $display("FAIL mthi_after got=%b exp=00", {md_busy, stall}); end
  endtask

  task automatic test_random();
    int rfn[14] = '{'h21, 0, 2, 3, 8, 9, 'h10, 'h12, 'h18, 'h19, 'h1a, 'h1b, 'h11, 'h13};
    int iop[21] = '{9, 'ha, 'hb, 'hc, 'hd, 'he, 'h20, 'h21, 'h23, 'h24, 'h25, 6, 7, 'h28, 'h29, 'h2b, 4, 5, 'hf, 2, 3};
    int r;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0)
        ir_d = rtype($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), rfn[$urandom_range(0, 13)]);
      else
        ir_d = itype(iop[$urandom_range(0, 20)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      ex_regwrite = 1'($urandom); ex_is_load = 1'($urandom); ex_wreg = 5'($urandom_range(0, 3));
      mem_is_load = 1'($urandom); mem_wreg = 5'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      ex_md_op = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      reset = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (stall !== ref_stall() || pc_en !== !ref_stall() || ifid_en !== !ref_stall() || idex_flush !== ref_stall() ||
          md_busy !== (m_rem > 0) || md_count !== 4'(m_rem) || stall_cycles !== m_cnt) begin
        errors++;
        $display("FAIL rand[%0d] ir=%h got st=%0b busy=%0b cnt=%0d scyc=%0d exp st=%0b rem=%0d scyc=%0d",
                 n, ir_d, stall, md_busy, md_count, stall_cycles, ref_stall(), m_rem, m_cnt);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; idle_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_shift();
    test_mult();
    test_div();
    test_mthi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
